// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states and
// the default datapath width.
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADC  = 4'b0001;
    localparam logic [3:0] OP_ADZ  = 4'b0010;
    localparam logic [3:0] OP_ADL  = 4'b0011;
    localparam logic [3:0] OP_NAND = 4'b0100;
    localparam logic [3:0] OP_NDC  = 4'b0101;
    localparam logic [3:0] OP_NDZ  = 4'b0110;
    localparam logic [3:0] OP_ADI  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    function automatic logic is_cond_carry(input logic [3:0] op);
        return (op == OP_ADC) || (op == OP_NDC);
    endfunction

    function automatic logic is_cond_zero(input logic [3:0] op);
        return (op == OP_ADZ) || (op == OP_NDZ);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between an ALU client and alu_seq.
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] bus_a;
    logic [WIDTH-1:0] bus_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_alu;
    logic             out_wr_en;
    logic             carry_flag;
    logic             zero_flag;
    logic             busy;

    modport master (
        output in_valid, alu_control, bus_a, bus_b, out_ready,
        input  in_ready, out_valid, out_alu, out_wr_en, carry_flag, zero_flag, busy
    );

    modport slave (
        input  in_valid, alu_control, bus_a, bus_b, out_ready,
        output in_ready, out_valid, out_alu, out_wr_en, carry_flag, zero_flag, busy
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiplier: operands latched on start, one partial product
// per clock, done asserted once WIDTH iterations have been accumulated.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic               running_q, running_d;

    always_comb begin
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        running_d = running_q;
        if (start_i) begin
            mcand_d   = {{WIDTH{1'b0}}, a_i};
            acc_d     = '0;
            mplier_d  = b_i;
            count_d   = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            if (count_q == LAST) begin
                // Result is consumed by the parent on this edge.
                running_d = 1'b0;
            end else begin
                acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

    assign done_o    = running_q && (count_q == LAST);
    assign product_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready request and result handshakes, a registered
// carry/zero CCR, conditional ops and an optional multi-cycle multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter bit MUL_EN = 1'b1
) (
    input logic       clk,
    input logic       reset_n,
    alu_seq_if.slave  bus
);

    state_e state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_alu_q, out_alu_d;
    logic             out_wr_en_q, out_wr_en_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             in_ready;
    logic             busy;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    logic             op_is_mul;
    logic             op_legal;
    logic             cond_ok;
    logic             exec;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_adl;
    logic [WIDTH-1:0] nand_res;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             res_carry;

    assign op     = bus.alu_control;
    assign a      = bus.bus_a;
    assign b      = bus.bus_b;
    assign accept = bus.in_valid && in_ready;

    // Opcode decode; conditions read the registered CCR, which already
    // reflects the previous op because flags load with its result.
    always_comb begin
        op_is_mul = MUL_EN && (op == OP_MUL);
        op_legal  = (op <= OP_SUB) || op_is_mul;
        cond_ok   = 1'b1;
        if (is_cond_carry(op)) begin
            cond_ok = carry_q;
        end else if (is_cond_zero(op)) begin
            cond_ok = zero_q;
        end
        exec = op_legal && cond_ok;
    end

    assign sum_add  = {1'b0, a} + {1'b0, b};
    assign sum_adl  = {1'b0, a} + {1'b0, b[WIDTH-2:0], 1'b0};
    assign nand_res = ~(a & b);
    assign diff     = a - b;

    always_comb begin
        res       = sum_add[WIDTH-1:0];
        res_carry = sum_add[WIDTH];
        case (op)
            OP_ADL: begin
                res       = sum_adl[WIDTH-1:0];
                res_carry = sum_adl[WIDTH];
            end
            OP_NAND, OP_NDC, OP_NDZ: begin
                res       = nand_res;
                res_carry = carry_q;
            end
            OP_SUB: begin
                res       = diff;
                res_carry = (a >= b);
            end
            default: ;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && op_is_mul) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_done) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (state_q == MUL_BUSY);
        in_ready = (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    end

    // Result register and CCR next-state
    always_comb begin
        out_valid_d = out_valid_q && !bus.out_ready;
        out_alu_d   = out_alu_q;
        out_wr_en_d = out_wr_en_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        mul_start   = 1'b0;
        if (accept) begin
            if (op_is_mul) begin
                mul_start = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                if (exec) begin
                    out_alu_d   = res;
                    out_wr_en_d = 1'b1;
                    carry_d     = res_carry;
                    zero_d      = (res == '0);
                end else begin
                    out_alu_d   = '0;
                    out_wr_en_d = 1'b0;
                end
            end
        end else if ((state_q == MUL_BUSY) && mul_done) begin
            out_valid_d = 1'b1;
            out_alu_d   = mul_product[WIDTH-1:0];
            out_wr_en_d = 1'b1;
            carry_d     = |mul_product[2*WIDTH-1:WIDTH];
            zero_d      = (mul_product[WIDTH-1:0] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_alu_q   <= '0;
            out_wr_en_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_alu_q   <= out_alu_d;
            out_wr_en_q <= out_wr_en_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_seq #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk       (clk),
                .reset_n   (reset_n),
                .start_i   (mul_start),
                .a_i       (a),
                .b_i       (b),
                .done_o    (mul_done),
                .product_o (mul_product)
            );
        end else begin : g_no_mul
            logic unused_mul_start;
            assign unused_mul_start = mul_start;
            assign mul_done         = 1'b0;
            assign mul_product      = '0;
        end
    endgenerate

    assign bus.in_ready   = in_ready;
    assign bus.busy       = busy;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_alu    = out_alu_q;
    assign bus.out_wr_en  = out_wr_en_q;
    assign bus.carry_flag = carry_q;
    assign bus.zero_flag  = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a 16-bit instance with MUL and an 8-bit
// instance without MUL, checked against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk;
    logic reset_n;

    int n_checks;
    int n_fail;

    bit mc16, mz16, mc8, mz8;

    alu_seq_if #(.WIDTH(16)) b16 ();
    alu_seq_if #(.WIDTH(8))  b8 ();

    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) u_dut16 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b16.slave)
    );

    alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) u_dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain arithmetic on the architectural rules.
    task automatic model(input int w, input bit mul_en, input logic [3:0] op,
                         input longint unsigned a, input longint unsigned b,
                         inout bit c, inout bit z,
                         output longint unsigned res, output bit wr);
        longint unsigned mask, full;
        bit cond_ok, legal, new_c;
        mask    = (64'd1 << w) - 64'd1;
        cond_ok = (op == 4'd1 || op == 4'd5) ? c : (op == 4'd2 || op == 4'd6) ? z : 1'b1;
        legal   = (op <= 4'd8) || (op == 4'd9 && mul_en);
        res     = 0;
        new_c   = c;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd7: begin
                full = a + b; res = full & mask; new_c = (full >> w) != 0;
            end
            4'd3: begin
                full = a + ((b << 1) & mask); res = full & mask; new_c = (full >> w) != 0;
            end
            4'd4, 4'd5, 4'd6: res = ~(a & b) & mask;
            4'd8: begin
                res = (a - b) & mask; new_c = (a >= b);
            end
            4'd9: begin
                full = a * b; res = full & mask; new_c = (full >> w) != 0;
            end
            default: ;
        endcase
        if (legal && cond_ok) begin
            c  = new_c;
            z  = (res == 0);
            wr = 1'b1;
        end else begin
            res = 0;
            wr  = 1'b0;
        end
    endtask

    task automatic send16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int n;
        @(negedge clk);
        b16.alu_control = op;
        b16.bus_a       = a;
        b16.bus_b       = b;
        b16.in_valid    = 1'b1;
        n = 0;
        while (b16.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send16_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        b8.alu_control = op;
        b8.bus_a       = a;
        b8.bus_b       = b;
        b8.in_valid    = 1'b1;
        n = 0;
        while (b8.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++; n_fail++;
            $display("FAIL send8_timeout: in_ready got 0 expected 1");
        end
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 7;
        if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", b16.out_valid); end
        if (b16.out_alu !== 16'h0) begin n_fail++; $display("FAIL reset_out_alu: got %h expected 0000", b16.out_alu); end
        if (b16.out_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", b16.out_wr_en); end
        if (b16.carry_flag !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b expected 0", b16.carry_flag); end
        if (b16.zero_flag !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b expected 0", b16.zero_flag); end
        if (b16.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", b16.busy); end
        if (b8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset8_out_valid: got %b expected 0", b8.out_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        mc16 = 0; mz16 = 0; mc8 = 0; mz8 = 0;
        @(posedge clk); #1;
        n_checks++;
        if (b16.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", b16.in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_add_carry();
        longint unsigned er; bit ew;
        send16(OP_ADD, 16'hFFFF, 16'h0001);
        model(16, 1'b1, OP_ADD, 64'hFFFF, 64'h1, mc16, mz16, er, ew);
        n_checks += 5;
        if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL add_out_valid: got %b expected 1", b16.out_valid); end
        if (b16.out_alu !== 16'h0000) begin n_fail++; $display("FAIL add_out_alu: got %h expected 0000", b16.out_alu); end
        if (b16.carry_flag !== 1'b1) begin n_fail++; $display("FAIL add_carry: got %b expected 1", b16.carry_flag); end
        if (b16.zero_flag !== 1'b1) begin n_fail++; $display("FAIL add_zero: got %b expected 1", b16.zero_flag); end
        if (b16.out_wr_en !== 1'b1) begin n_fail++; $display("FAIL add_wr_en: got %b expected 1", b16.out_wr_en); end
        $display("test_add_carry: FFFF+0001 -> %h c=%b z=%b", b16.out_alu, b16.carry_flag, b16.zero_flag);
    endtask

    task automatic test_conditional();
        longint unsigned er; bit ew;
        send16(OP_ADD, 16'h0001, 16'h0001);
        model(16, 1'b1, OP_ADD, 64'h1, 64'h1, mc16, mz16, er, ew);
        send16(OP_ADC, 16'h0005, 16'h0003);
        model(16, 1'b1, OP_ADC, 64'h5, 64'h3, mc16, mz16, er, ew);
        n_checks += 4;
        if (b16.out_alu !== 16'h0000) begin n_fail++; $display("FAIL adc_skip_alu: got %h expected 0000", b16.out_alu); end
        if (b16.out_wr_en !== 1'b0) begin n_fail++; $display("FAIL adc_skip_wr_en: got %b expected 0", b16.out_wr_en); end
        if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL adc_skip_valid: got %b expected 1", b16.out_valid); end
        if ({b16.carry_flag, b16.zero_flag} !== 2'b00) begin n_fail++; $display("FAIL adc_skip_flags: got %b%b expected 00", b16.carry_flag, b16.zero_flag); end
        $display("test_conditional: skipped ADC -> %h wr=%b", b16.out_alu, b16.out_wr_en);
        send16(OP_ADD, 16'h8000, 16'h8000);
        model(16, 1'b1, OP_ADD, 64'h8000, 64'h8000, mc16, mz16, er, ew);
        send16(OP_ADC, 16'h0005, 16'h0003);
        model(16, 1'b1, OP_ADC, 64'h5, 64'h3, mc16, mz16, er, ew);
        n_checks += 2;
        if (b16.out_alu !== 16'h0008) begin n_fail++; $display("FAIL adc_exec_alu: got %h expected 0008", b16.out_alu); end
        if (b16.out_wr_en !== 1'b1) begin n_fail++; $display("FAIL adc_exec_wr_en: got %b expected 1", b16.out_wr_en); end
        $display("test_conditional: executed ADC -> %h wr=%b", b16.out_alu, b16.out_wr_en);
    endtask

    task automatic test_mul();
        longint unsigned er; bit ew;
        int bad_busy;
        bad_busy = 0;
        send16(OP_MUL, 16'h0100, 16'h0100);
        model(16, 1'b1, OP_MUL, 64'h100, 64'h100, mc16, mz16, er, ew);
        if (b16.busy !== 1'b1 || b16.in_ready !== 1'b0) bad_busy++;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin
                // Stray request while busy must be ignored
                b16.alu_control = OP_ADD;
                b16.bus_a       = 16'h1234;
                b16.bus_b       = 16'h4321;
                b16.in_valid    = 1'b1;
            end
            if (k == 10) b16.in_valid = 1'b0;
            if (k < 17) begin
                if (b16.busy !== 1'b1 || b16.in_ready !== 1'b0 || b16.out_valid !== 1'b0) bad_busy++;
            end
        end
        n_checks += 6;
        if (bad_busy != 0) begin n_fail++; $display("FAIL mul_busy_window: got %0d bad cycles expected 0", bad_busy); end
        if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_latency_valid: got %b expected 1", b16.out_valid); end
        if (b16.out_alu !== er[15:0]) begin n_fail++; $display("FAIL mul_alu: got %h expected %h", b16.out_alu, er[15:0]); end
        if (b16.carry_flag !== 1'b1) begin n_fail++; $display("FAIL mul_carry: got %b expected 1", b16.carry_flag); end
        if (b16.zero_flag !== 1'b1) begin n_fail++; $display("FAIL mul_zero: got %b expected 1", b16.zero_flag); end
        if (b16.busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_end: got %b expected 0", b16.busy); end
        $display("test_mul: 0100*0100 -> %h c=%b z=%b", b16.out_alu, b16.carry_flag, b16.zero_flag);
        @(posedge clk); #1;
        n_checks++;
        if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_stray_accept: out_valid got %b expected 0", b16.out_valid); end
    endtask

    task automatic test_back_to_back();
        longint unsigned r1, r2, r3; bit ew;
        int bad;
        bad = 0;
        repeat (2) @(negedge clk);
        b16.out_ready = 1'b0;
        send16(OP_ADD, 16'h1111, 16'h2222);
        model(16, 1'b1, OP_ADD, 64'h1111, 64'h2222, mc16, mz16, r1, ew);
        b16.alu_control = OP_SUB;
        b16.bus_a       = 16'h5000;
        b16.bus_b       = 16'h0001;
        b16.in_valid    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (b16.in_ready !== 1'b0 || b16.out_valid !== 1'b1 || b16.out_alu !== r1[15:0]) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        b16.out_ready = 1'b1;
        @(posedge clk); #1;
        model(16, 1'b1, OP_SUB, 64'h5000, 64'h1, mc16, mz16, r2, ew);
        n_checks += 2;
        if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1: got %b expected 1", b16.out_valid); end
        if (b16.out_alu !== r2[15:0]) begin n_fail++; $display("FAIL b2b_alu1: got %h expected %h", b16.out_alu, r2[15:0]); end
        b16.alu_control = OP_NAND;
        b16.bus_a       = 16'hF0F0;
        b16.bus_b       = 16'h3C3C;
        @(posedge clk); #1;
        b16.in_valid = 1'b0;
        model(16, 1'b1, OP_NAND, 64'hF0F0, 64'h3C3C, mc16, mz16, r3, ew);
        n_checks += 3;
        if (b16.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2: got %b expected 1", b16.out_valid); end
        if (b16.out_alu !== r3[15:0]) begin n_fail++; $display("FAIL b2b_alu2: got %h expected %h", b16.out_alu, r3[15:0]); end
        if (b16.carry_flag !== mc16) begin n_fail++; $display("FAIL b2b_carry: got %b expected %b", b16.carry_flag, mc16); end
        $display("test_back_to_back: %h then %h", r2[15:0], b16.out_alu);
    endtask

    task automatic test_random();
        longint unsigned er, a, b; bit ew;
        logic [3:0] op;
        int n;
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: a = 0;
                1: a = 64'hFFFF;
                default: a = longint'($urandom_range(0, 65535));
            endcase
            case ($urandom_range(0, 3))
                0: b = 0;
                1: b = 64'hFFFF;
                default: b = longint'($urandom_range(0, 65535));
            endcase
            send16(op, a[15:0], b[15:0]);
            model(16, 1'b1, op, a, b, mc16, mz16, er, ew);
            n = 0;
            while (b16.out_valid !== 1'b1 && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            n_checks += 5;
            if (n != ((op == OP_MUL) ? 17 : 0)) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, n, (op == OP_MUL) ? 17 : 0); end
            if (b16.out_alu !== er[15:0]) begin n_fail++; $display("FAIL rand_alu[%0d] op=%h: got %h expected %h", i, op, b16.out_alu, er[15:0]); end
            if (b16.out_wr_en !== ew) begin n_fail++; $display("FAIL rand_wr_en[%0d] op=%h: got %b expected %b", i, op, b16.out_wr_en, ew); end
            if (b16.carry_flag !== mc16) begin n_fail++; $display("FAIL rand_carry[%0d] op=%h: got %b expected %b", i, op, b16.carry_flag, mc16); end
            if (b16.zero_flag !== mz16) begin n_fail++; $display("FAIL rand_zero[%0d] op=%h: got %b expected %b", i, op, b16.zero_flag, mz16); end
            $display("rand[%0d] op=%h a=%h b=%h -> %h wr=%b c=%b z=%b", i, op, a[15:0], b[15:0], b16.out_alu, b16.out_wr_en, b16.carry_flag, b16.zero_flag);
        end
    endtask

    task automatic test_reset_mid_mul();
        int seen;
        seen = 0;
        send16(OP_MUL, 16'h00FF, 16'h0003);
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_checks += 5;
        if (b16.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mul_valid: got %b expected 0", b16.out_valid); end
        if (b16.busy !== 1'b0) begin n_fail++; $display("FAIL rst_mul_busy: got %b expected 0", b16.busy); end
        if (b16.out_alu !== 16'h0) begin n_fail++; $display("FAIL rst_mul_alu: got %h expected 0000", b16.out_alu); end
        if (b16.out_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_mul_wr_en: got %b expected 0", b16.out_wr_en); end
        if ({b16.carry_flag, b16.zero_flag} !== 2'b00) begin n_fail++; $display("FAIL rst_mul_flags: got %b%b expected 00", b16.carry_flag, b16.zero_flag); end
        @(negedge clk);
        reset_n = 1'b1;
        mc16 = 0; mz16 = 0; mc8 = 0; mz8 = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (b16.out_valid !== 1'b0 || b16.busy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin n_fail++; $display("FAIL rst_mul_no_result: got %0d active cycles expected 0", seen); end
        $display("test_reset_mid_mul: aborted MUL, post-reset activity cycles %0d", seen);
    endtask

    task automatic test_width8();
        longint unsigned er; bit ew;
        send8(OP_SUB, 8'h03, 8'h05);
        model(8, 1'b0, OP_SUB, 64'h3, 64'h5, mc8, mz8, er, ew);
        n_checks += 4;
        if (b8.out_alu !== 8'hFE) begin n_fail++; $display("FAIL sub8_alu: got %h expected fe", b8.out_alu); end
        if (b8.carry_flag !== 1'b0) begin n_fail++; $display("FAIL sub8_carry: got %b expected 0", b8.carry_flag); end
        if (b8.zero_flag !== 1'b0) begin n_fail++; $display("FAIL sub8_zero: got %b expected 0", b8.zero_flag); end
        if (b8.out_wr_en !== 1'b1) begin n_fail++; $display("FAIL sub8_wr_en: got %b expected 1", b8.out_wr_en); end
        $display("test_width8: 03-05 -> %h c=%b z=%b", b8.out_alu, b8.carry_flag, b8.zero_flag);
        send8(4'hF, 8'h12, 8'h34);
        model(8, 1'b0, 4'hF, 64'h12, 64'h34, mc8, mz8, er, ew);
        n_checks += 3;
        if (b8.out_wr_en !== 1'b0) begin n_fail++; $display("FAIL ill8_wr_en: got %b expected 0", b8.out_wr_en); end
        if (b8.out_alu !== 8'h00) begin n_fail++; $display("FAIL ill8_alu: got %h expected 00", b8.out_alu); end
        if ({b8.carry_flag, b8.zero_flag} !== {mc8, mz8}) begin n_fail++; $display("FAIL ill8_flags: got %b%b expected %b%b", b8.carry_flag, b8.zero_flag, mc8, mz8); end
        send8(OP_ADD, 8'hFF, 8'h01);
        model(8, 1'b0, OP_ADD, 64'hFF, 64'h1, mc8, mz8, er, ew);
        send8(4'hF, 8'h00, 8'h00);
        model(8, 1'b0, 4'hF, 64'h0, 64'h0, mc8, mz8, er, ew);
        n_checks++;
        if ({b8.carry_flag, b8.zero_flag} !== 2'b11) begin n_fail++; $display("FAIL ill8_flags_hold: got %b%b expected 11", b8.carry_flag, b8.zero_flag); end
        send8(OP_MUL, 8'h07, 8'h09);
        model(8, 1'b0, OP_MUL, 64'h7, 64'h9, mc8, mz8, er, ew);
        n_checks += 4;
        if (b8.out_valid !== 1'b1) begin n_fail++; $display("FAIL mul8_illegal_valid: got %b expected 1", b8.out_valid); end
        if (b8.out_wr_en !== 1'b0 || b8.out_alu !== 8'h00) begin n_fail++; $display("FAIL mul8_illegal_result: got wr=%b alu=%h expected wr=0 alu=00", b8.out_wr_en, b8.out_alu); end
        if (b8.busy !== 1'b0) begin n_fail++; $display("FAIL mul8_illegal_busy: got %b expected 0", b8.busy); end
        if ({b8.carry_flag, b8.zero_flag} !== {mc8, mz8}) begin n_fail++; $display("FAIL mul8_illegal_flags: got %b%b expected %b%b", b8.carry_flag, b8.zero_flag, mc8, mz8); end
        $display("test_width8: illegal MUL -> alu=%h wr=%b", b8.out_alu, b8.out_wr_en);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        b16.in_valid = 1'b0; b16.alu_control = 4'h0; b16.bus_a = '0; b16.bus_b = '0; b16.out_ready = 1'b1;
        b8.in_valid  = 1'b0; b8.alu_control  = 4'h0; b8.bus_a  = '0; b8.bus_b  = '0; b8.out_ready  = 1'b1;
        test_reset();
        test_add_carry();
        test_conditional();
        test_mul();
        test_back_to_back();
        test_random();
        test_reset_mid_mul();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, 16, datapath width in bits (legal 4..64).
REQ-002 Parameter: MUL_EN, 1, 1 includes the multi-cycle MUL op; 0 treats MUL as illegal.
REQ-003 Reset is synchronous and active-low on one clock; the block SHALL have ports clk and reset_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operation request.
REQ-007 in_ready  output  1  block accepts request this cycle.
REQ-008 alu_control  input  4  opcode, encodings in shared package.
REQ-009 bus_a, bus_b  input  WIDTH each  operands.
REQ-010 out_valid  output  1  result held in output register.
REQ-011 out_ready  input  1  consumer takes result this cycle.
REQ-012 out_alu  output  WIDTH  result.
REQ-013 out_wr_en  output  1  result is to be written back; 0 for skipped conditional or illegal op.
REQ-014 carry_flag, zero_flag  output  1 each  architectural CCR.
REQ-015 busy  output  1  MUL in progress.

Function
REQ-016 Ops SHALL be ADD 0000, ADC 0001 (if carry), ADZ 0010 (if zero), ADL 0011 (a + (b<<1)), NAND 0100, NDC 0101 (if carry), NDZ 0110 (if zero), ADI 0111, SUB 1000, MUL 1001; others illegal.
REQ-017 Transfer occurs on in_valid && in_ready; in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-018 Single-cycle ops SHALL load out_alu/out_wr_en and set out_valid on the clock edge of acceptance (latency 1).
REQ-019 MUL SHALL take WIDTH cycles of shift-add in state MUL_BUSY, then load result the following edge (latency WIDTH+1); busy=1 throughout MUL_BUSY.
REQ-020 FSM states IDLE, MUL_BUSY; IDLE->MUL_BUSY on accepted MUL; MUL_BUSY->IDLE when iteration count reaches WIDTH and the result loads.
REQ-021 out_valid SHALL clear on out_valid && out_ready unless a new result loads the same edge (back-to-back throughput 1/cycle).
REQ-022 Add ops: result = low WIDTH bits of (WIDTH+1)-bit sum; carry_flag = bit WIDTH; ADL shift discards b's MSB.
REQ-023 SUB: result = a - b mod 2^WIDTH; carry_flag = 1 iff a >= b unsigned.
REQ-024 MUL: result = low WIDTH bits of full product; carry_flag = 1 iff upper WIDTH bits nonzero.
REQ-025 NAND ops: result = ~(a & b); carry_flag unchanged.
REQ-026 zero_flag SHALL be set to (result == 0) for every executed op; flags update on the same edge the result loads.
REQ-027 Conditions SHALL be sampled from the registered flags at acceptance, which include the immediately preceding op.
REQ-028 Skipped conditional: out_alu = 0, out_wr_en = 0, out_valid = 1, both flags unchanged.
REQ-029 Illegal op (incl. MUL with MUL_EN=0): out_alu = 0, out_wr_en = 0, out_valid = 1, flags unchanged, latency 1.
REQ-030 in_valid during MUL_BUSY SHALL be ignored (in_ready=0); operands of a MUL SHALL be latched at acceptance.

Reset
REQ-031 When reset_n=0 at a clock edge: state=IDLE, out_valid=0, out_alu=0, out_wr_en=0, carry_flag=0, zero_flag=0, busy=0, iteration count=0.
REQ-032 Reset mid-MUL SHALL abort the operation with no result produced; reset SHALL override any simultaneous handshake.

Structure
REQ-033 Package alu_pkg SHALL hold opcode constants, FSM state enum and default WIDTH.
REQ-034 Sub-module alu_mul_seq (start, operands, done, 2*WIDTH product) SHALL implement the shift-add multiplier; instantiate only when MUL_EN=1.

Verification
REQ-035 WIDTH=16: ADD 0xFFFF+0x0001 -> out_alu 0x0000, carry 1, zero 1, out_valid next cycle.
REQ-036 With carry=0, ADC 5+3 -> out_alu 0, out_wr_en 0, flags unchanged; then ADD 0x8000+0x8000 followed by ADC 5+3 -> 0x0008, wr_en 1.
REQ-037 MUL 0x0100*0x0100 -> after 17 cycles out_alu 0x0000, carry 1, zero 1; in_ready 0 and busy 1 for the duration.
REQ-038 out_ready held 0 after ADD: in_ready stays 0, out_alu stable; out_ready=1 with in_valid same cycle -> new result next edge, no bubble.
REQ-039 reset_n=0 in MUL cycle 5 -> all outputs at reset values next edge, no out_valid pulse afterwards.
REQ-040 WIDTH=8 SUB 0x03-0x05 -> 0xFE, carry 0, zero 0; opcode 1111 -> out_wr_en 0, flags unchanged.
